// File: rtl/apb_pkg.sv
// Shared types and helpers for the CPU-bus to APB4 bridge: FSM state encoding,
// access-width codes, and the lane strobe / write-data replication rules.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam logic [2:0] SIZE_BYTE = 3'b000;
  localparam logic [2:0] SIZE_HALF = 3'b001;
  localparam logic [2:0] SIZE_WORD = 3'b010;

  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

  // Reads never strobe; unknown width codes fall back to a full word.
  function automatic logic [3:0] gen_pstrb(input logic [2:0] size,
                                           input logic [1:0] addr_lo,
                                           input logic       write);
    logic [3:0] s;
    s = 4'b0000;
    if (write) begin
      case (size)
        SIZE_BYTE: s = 4'b0001 << addr_lo;
        SIZE_HALF: s = 4'b0011 << {addr_lo[1], 1'b0};
        SIZE_WORD: s = 4'b1111;
        default:   s = 4'b1111;
      endcase
    end
    return s;
  endfunction

  function automatic logic [31:0] align_wdata(input logic [2:0]  size,
                                              input logic [31:0] data);
    logic [31:0] w;
    case (size)
      SIZE_BYTE: w = {4{data[7:0]}};
      SIZE_HALF: w = {2{data[15:0]}};
      default:   w = data;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational address decode to one-hot slave select, slave index and hit flag.
// Zero latency; no state, no backpressure.
module apb_addr_decoder #(
  parameter int          N_SLAVES    = 4,
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          REGION_BITS = 12
) (
  input  logic [31:0]         addr,
  output logic [N_SLAVES-1:0] sel,
  output logic [3:0]          idx,
  output logic                hit
);

  logic in_window;
  logic unused_addr_bits;

  // Only the window and index fields matter; fold the rest so they read as consumed.
  assign unused_addr_bits = ^addr;

  always_comb begin
    idx       = addr[REGION_BITS +: 4];
    in_window = (addr[31:16] == BASE_ADDR[31:16]);
    hit       = in_window && (32'(idx) < N_SLAVES);
    sel       = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (hit && (idx == 4'(i))) sel[i] = 1'b1;
    end
  end

endmodule

// File: rtl/apb_master_bridge.sv
// CPU simple-bus responder issuing one APB4 SETUP/ACCESS per transfer; ready no earlier than T+2.
// Stalls in ACCESS on PREADY low; APB_TIMEOUT_EN adds a watchdog forcing completion with 0xDEADBEEF.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int          N_SLAVES       = 4,
  parameter logic [31:0] BASE_ADDR      = 32'h1000_0000,
  parameter int          REGION_BITS    = 12,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     transfer,
  input  logic                     busWe,
  input  logic [31:0]              busAddr,
  input  logic [31:0]              busWData,
  input  logic [2:0]               strb,
  output logic [31:0]              busRData,
  output logic                     ready,
  output logic [31:0]              PADDR,
  output logic                     PWRITE,
  output logic [N_SLAVES-1:0]      PSEL,
  output logic                     PENABLE,
  output logic [31:0]              PWDATA,
  output logic [3:0]               PSTRB,
  input  logic [N_SLAVES-1:0][31:0] PRDATA,
  input  logic [N_SLAVES-1:0]      PREADY
);

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_SETUP  = SETUP;
  localparam logic [1:0] ST_ACCESS = ACCESS;

  logic [1:0]          state_q, state_d;
  logic [31:0]         addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          pstrb_q, pstrb_d;
  logic                write_q, write_d;
  logic                hit_q, hit_d;
  logic [N_SLAVES-1:0] sel_q, sel_d;

  logic [N_SLAVES-1:0] dec_sel;
  logic [3:0]          unused_dec_idx;
  logic                dec_hit;
  logic                sel_pready;
  logic [31:0]         sel_prdata;
  logic                timeout;
  logic                done;
  logic                in_xfer;

  apb_addr_decoder #(
    .N_SLAVES    (N_SLAVES),
    .BASE_ADDR   (BASE_ADDR),
    .REGION_BITS (REGION_BITS)
  ) u_dec (
    .addr (busAddr),
    .sel  (dec_sel),
    .idx  (unused_dec_idx),
    .hit  (dec_hit)
  );

  // Non-selected slaves are don't-care, so mux purely on the latched one-hot select.
  always_comb begin
    sel_pready = 1'b0;
    sel_prdata = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (sel_q[i]) begin
        sel_pready = PREADY[i];
        sel_prdata = PRDATA[i];
      end
    end
  end

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_SETUP) begin
      cnt_d = '0;
    end else if ((state_q == ST_ACCESS) && !sel_pready &&
                 (cnt_q != CNT_W'(TIMEOUT_CYCLES))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign timeout = (state_q == ST_ACCESS) && hit_q && (cnt_q == CNT_W'(TIMEOUT_CYCLES));
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  // A miss has no slave to wait for, so it completes on the first ACCESS cycle.
  assign done = !hit_q || sel_pready || timeout;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    pstrb_d = pstrb_q;
    write_d = write_q;
    hit_d   = hit_q;
    sel_d   = sel_q;
    case (state_q)
      ST_IDLE: begin
        if (transfer) begin
          state_d = ST_SETUP;
          addr_d  = busAddr;
          wdata_d = align_wdata(strb, busWData);
          pstrb_d = gen_pstrb(strb, busAddr[1:0], busWe);
          write_d = busWe;
          hit_d   = dec_hit;
          sel_d   = dec_sel;
        end
      end
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: if (done) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      pstrb_q <= '0;
      write_q <= 1'b0;
      hit_q   <= 1'b0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      pstrb_q <= pstrb_d;
      write_q <= write_d;
      hit_q   <= hit_d;
      sel_q   <= sel_d;
    end
  end

  // Reset masks handshake outputs immediately so an abandoned transfer never pulses ready.
  always_comb begin
    in_xfer  = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    PSEL     = (in_xfer && !reset) ? sel_q : '0;
    PENABLE  = (state_q == ST_ACCESS) && !reset;
    ready    = (state_q == ST_ACCESS) && done && !reset;
    PADDR    = addr_q;
    PWRITE   = write_q;
    PWDATA   = wdata_q;
    PSTRB    = pstrb_q;
    busRData = '0;
    if (ready) begin
      if (timeout && !sel_pready) busRData = TIMEOUT_RDATA;
      else if (hit_q && !write_q) busRData = sel_prdata;
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Randomized self-checking bench for apb_master_bridge against a spec-level model.
// Define APB_TIMEOUT_EN for both bench and RTL to exercise the ACCESS watchdog.
module tb_apb_master_bridge;

  localparam int NS = 4;
  localparam int TO = 16;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   transfer;
  logic                   busWe;
  logic [31:0]            busAddr;
  logic [31:0]            busWData;
  logic [2:0]             strb;
  logic [31:0]            busRData;
  logic                   ready;
  logic [31:0]            PADDR;
  logic                   PWRITE;
  logic [NS-1:0]          PSEL;
  logic                   PENABLE;
  logic [31:0]            PWDATA;
  logic [3:0]             PSTRB;
  logic [NS-1:0][31:0]    PRDATA;
  logic [NS-1:0]          PREADY;

  int n_pass  = 0;
  int n_total = 0;

  int            obs_cycle;
  logic [31:0]   obs_rdata, obs_paddr, obs_pwdata;
  logic [3:0]    obs_pstrb;
  logic [NS-1:0] obs_psel;
  logic          obs_pwrite, obs_penable_setup, obs_early, obs_stable, obs_after_ok;

  always #5 clk = ~clk;

  apb_master_bridge #(
    .N_SLAVES       (NS),
    .BASE_ADDR      (32'h1000_0000),
    .REGION_BITS    (12),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .transfer (transfer),
    .busWe    (busWe),
    .busAddr  (busAddr),
    .busWData (busWData),
    .strb     (strb),
    .busRData (busRData),
    .ready    (ready),
    .PADDR    (PADDR),
    .PWRITE   (PWRITE),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWDATA   (PWDATA),
    .PSTRB    (PSTRB),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY)
  );

  // ---------------- reference model ----------------
  function automatic int m_idx(input logic [31:0] a);
    return int'((a >> 12) & 32'hF);
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return (a[31:16] == 16'h1000) && (m_idx(a) < NS);
  endfunction

  function automatic logic [NS-1:0] m_psel(input logic [31:0] a);
    return m_hit(a) ? NS'(1 << m_idx(a)) : '0;
  endfunction

  function automatic logic [3:0] m_pstrb(input logic we, input logic [2:0] sz, input logic [31:0] a);
    if (!we) return 4'd0;
    if (sz == 3'd0) return 4'(1 << (a % 4));
    if (sz == 3'd1) return 4'(3 << (a & 32'd2));
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_pwdata(input logic [2:0] sz, input logic [31:0] d);
    if (sz == 3'd0) return (d & 32'hFF) * 32'h0101_0101;
    if (sz == 3'd1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic int m_cycle(input logic [31:0] a, input int waits);
    if (!m_hit(a)) return 2;
`ifdef APB_TIMEOUT_EN
    if (waits > TO) return 2 + TO;
`endif
    return 2 + waits;
  endfunction

  function automatic logic [31:0] m_rdata(input logic we, input logic [31:0] a, input int waits);
    if (!m_hit(a)) return 32'd0;
`ifdef APB_TIMEOUT_EN
    if (waits > TO) return 32'hDEAD_BEEF;
`endif
    if (we) return 32'd0;
    return PRDATA[m_idx(a)];
  endfunction

  // Drives one transfer and records what the APB side and CPU side showed; cycle 0 = transfer cycle.
  task automatic do_txn(input logic we, input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] sz, input int waits);
    int  ai;
    bit  h;
    ai = m_idx(a);
    h  = m_hit(a);
    for (int s = 0; s < NS; s++) PRDATA[s] = $urandom;
    @(posedge clk); #1;
    transfer = 1'b1; busWe = we; busAddr = a; busWData = d; strb = sz;
    PREADY = NS'($urandom);
    if (h) PREADY[ai] = 1'b0;
    @(negedge clk);
    obs_early = ready;
    @(posedge clk); #1;
    transfer = 1'b0; busWe = 1'($urandom); busAddr = $urandom; busWData = $urandom; strb = 3'($urandom);
    PREADY = NS'($urandom);
    @(negedge clk);
    obs_psel = PSEL; obs_penable_setup = PENABLE; obs_paddr = PADDR;
    obs_pwrite = PWRITE; obs_pwdata = PWDATA; obs_pstrb = PSTRB;
    obs_early = obs_early | ready;
    obs_cycle = -1; obs_stable = 1'b1; obs_rdata = 'x;
    for (int c = 2; c < 60 && obs_cycle < 0; c++) begin
      @(posedge clk); #1;
      PREADY = NS'($urandom);
      if (h) PREADY[ai] = ((c - 2) >= waits);
      @(negedge clk);
      if (PSEL !== obs_psel || PENABLE !== 1'b1 || PADDR !== obs_paddr ||
          PWRITE !== obs_pwrite || PWDATA !== obs_pwdata || PSTRB !== obs_pstrb)
        obs_stable = 1'b0;
      if (ready === 1'b1) begin
        obs_cycle = c;
        obs_rdata = busRData;
      end
    end
    @(posedge clk); #1;
    PREADY = '0;
    @(negedge clk);
    obs_after_ok = (ready === 1'b0) && (PSEL === '0) && (PENABLE === 1'b0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    reset = 1'b1; transfer = 1'b0; busWe = 1'b0; busAddr = '0; busWData = '0; strb = '0;
    PREADY = '0; PRDATA = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_total++; if (PSEL !== '0) $display("FAIL rst_psel: got %b want 0", PSEL); else n_pass++;
    n_total++; if (PENABLE !== 1'b0) $display("FAIL rst_penable: got %b want 0", PENABLE); else n_pass++;
    n_total++; if (PWRITE !== 1'b0) $display("FAIL rst_pwrite: got %b want 0", PWRITE); else n_pass++;
    n_total++; if (PADDR !== 32'd0) $display("FAIL rst_paddr: got %h want 0", PADDR); else n_pass++;
    n_total++; if (PWDATA !== 32'd0) $display("FAIL rst_pwdata: got %h want 0", PWDATA); else n_pass++;
    n_total++; if (PSTRB !== 4'd0) $display("FAIL rst_pstrb: got %b want 0", PSTRB); else n_pass++;
    n_total++; if (ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", ready); else n_pass++;
    n_total++; if (busRData !== 32'd0) $display("FAIL rst_rdata: got %h want 0", busRData); else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_word_write;
    do_txn(1'b1, 32'h1000_1004, 32'hCAFE_F00D, 3'b010, 0);
    n_total++; if (obs_psel !== 4'b0010) $display("FAIL ww_psel_setup: got %b want 0010", obs_psel); else n_pass++;
    n_total++; if (obs_penable_setup !== 1'b0) $display("FAIL ww_penable_setup: got %b want 0", obs_penable_setup); else n_pass++;
    n_total++; if (obs_stable !== 1'b1) $display("FAIL ww_access_stable: got %b want 1", obs_stable); else n_pass++;
    n_total++; if (obs_pstrb !== 4'b1111) $display("FAIL ww_pstrb: got %b want 1111", obs_pstrb); else n_pass++;
    n_total++; if (obs_pwdata !== 32'hCAFE_F00D) $display("FAIL ww_pwdata: got %h want cafef00d", obs_pwdata); else n_pass++;
    n_total++; if (obs_paddr !== 32'h1000_1004) $display("FAIL ww_paddr: got %h want 10001004", obs_paddr); else n_pass++;
    n_total++; if (obs_pwrite !== 1'b1) $display("FAIL ww_pwrite: got %b want 1", obs_pwrite); else n_pass++;
    n_total++; if (obs_cycle !== 2) $display("FAIL ww_ready_cycle: got %0d want 2", obs_cycle); else n_pass++;
    n_total++; if (obs_early !== 1'b0) $display("FAIL ww_early_ready: got %b want 0", obs_early); else n_pass++;
    n_total++; if (obs_after_ok !== 1'b1) $display("FAIL ww_idle_after: got %b want 1", obs_after_ok); else n_pass++;
  endtask

  task automatic test_byte_write;
    do_txn(1'b1, 32'h1000_0003, 32'h0000_00A5, 3'b000, 1);
    n_total++; if (obs_pstrb !== 4'b1000) $display("FAIL bw_pstrb: got %b want 1000", obs_pstrb); else n_pass++;
    n_total++; if (obs_pwdata !== 32'hA5A5_A5A5) $display("FAIL bw_pwdata: got %h want a5a5a5a5", obs_pwdata); else n_pass++;
    n_total++; if (obs_psel !== 4'b0001) $display("FAIL bw_psel: got %b want 0001", obs_psel); else n_pass++;
    n_total++; if (obs_cycle !== 3) $display("FAIL bw_ready_cycle: got %0d want 3", obs_cycle); else n_pass++;
  endtask

  task automatic test_wait_read;
    logic [31:0] exp_d;
    do_txn(1'b0, 32'h1000_2000, 32'h0, 3'b010, 3);
    exp_d = PRDATA[2];
    n_total++; if (obs_cycle !== 5) $display("FAIL wr_ready_cycle: got %0d want 5", obs_cycle); else n_pass++;
    n_total++; if (obs_rdata !== exp_d) $display("FAIL wr_rdata: got %h want %h", obs_rdata, exp_d); else n_pass++;
    n_total++; if (obs_stable !== 1'b1) $display("FAIL wr_stable: got %b want 1", obs_stable); else n_pass++;
    n_total++; if (obs_psel !== 4'b0100) $display("FAIL wr_psel: got %b want 0100", obs_psel); else n_pass++;
    n_total++; if (obs_pstrb !== 4'b0000) $display("FAIL wr_pstrb: got %b want 0000", obs_pstrb); else n_pass++;
  endtask

  task automatic test_decode_miss;
    do_txn(1'b0, 32'h2000_0000, 32'h0, 3'b010, 5);
    n_total++; if (obs_psel !== 4'b0000) $display("FAIL miss_psel: got %b want 0000", obs_psel); else n_pass++;
    n_total++; if (obs_stable !== 1'b1) $display("FAIL miss_stable: got %b want 1", obs_stable); else n_pass++;
    n_total++; if (obs_cycle !== 2) $display("FAIL miss_ready_cycle: got %0d want 2", obs_cycle); else n_pass++;
    n_total++; if (obs_rdata !== 32'd0) $display("FAIL miss_rdata: got %h want 0", obs_rdata); else n_pass++;
    do_txn(1'b1, 32'h1000_5008, 32'h1357_9BDF, 3'b010, 4);
    n_total++; if (obs_psel !== 4'b0000) $display("FAIL idxmiss_psel: got %b want 0000", obs_psel); else n_pass++;
    n_total++; if (obs_cycle !== 2) $display("FAIL idxmiss_ready_cycle: got %0d want 2", obs_cycle); else n_pass++;
  endtask

  task automatic test_reset_mid;
    logic [31:0] exp_d;
    @(posedge clk); #1;
    transfer = 1'b1; busWe = 1'b1; busAddr = 32'h1000_1010; busWData = 32'h5555_AAAA; strb = 3'b010;
    PREADY = '0;
    @(posedge clk); #1; transfer = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    n_total++; if (PENABLE !== 1'b1 || PSEL !== 4'b0010)
      $display("FAIL rm_stalled: got psel=%b penable=%b want 0010/1", PSEL, PENABLE); else n_pass++;
    @(posedge clk); #1;
    reset = 1'b1; PREADY = '1;
    @(negedge clk);
    n_total++; if (ready !== 1'b0) $display("FAIL rm_no_ready: got %b want 0", ready); else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_total++; if (PSEL !== '0 || PENABLE !== 1'b0 || ready !== 1'b0)
      $display("FAIL rm_dropped: got psel=%b penable=%b ready=%b want 0/0/0", PSEL, PENABLE, ready); else n_pass++;
    do_txn(1'b0, 32'h1000_300C, 32'h0, 3'b010, 2);
    exp_d = PRDATA[3];
    n_total++; if (obs_cycle !== 4) $display("FAIL rm_fresh_cycle: got %0d want 4", obs_cycle); else n_pass++;
    n_total++; if (obs_rdata !== exp_d) $display("FAIL rm_fresh_rdata: got %h want %h", obs_rdata, exp_d); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int mask;
    mask = 0;
    @(posedge clk); #1;
    transfer = 1'b1; busWe = 1'b1; busAddr = 32'h1000_3008; busWData = 32'h0BAD_F00D; strb = 3'b010;
    PREADY = '1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (ready === 1'b1) mask = mask | (1 << c);
      @(posedge clk); #1;
    end
    transfer = 1'b0;
    PREADY = '0;
    n_total++; if (mask !== ((1 << 2) | (1 << 5) | (1 << 8)))
      $display("FAIL b2b_ready_pattern: got %h want %h", mask, (1 << 2) | (1 << 5) | (1 << 8)); else n_pass++;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_random;
    logic [31:0] a, d, er;
    logic        we;
    logic [2:0]  sz;
    int          w, r;
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0) a = $urandom;
      else a = 32'h1000_0000 | (32'($urandom_range(0, 5)) << 12) | 32'($urandom_range(0, 4095));
      d  = $urandom;
      we = 1'($urandom);
      sz = 3'($urandom_range(0, 3));
      w  = $urandom_range(0, 4);
      do_txn(we, a, d, sz, w);
      er = m_rdata(we, a, w);
      n_total++; if (obs_psel !== m_psel(a)) $display("FAIL rnd_psel[%0d]: got %b want %b", k, obs_psel, m_psel(a)); else n_pass++;
      n_total++; if (obs_pstrb !== m_pstrb(we, sz, a)) $display("FAIL rnd_pstrb[%0d]: got %b want %b", k, obs_pstrb, m_pstrb(we, sz, a)); else n_pass++;
      n_total++; if (obs_paddr !== a || obs_pwrite !== we)
        $display("FAIL rnd_addr_dir[%0d]: got %h/%b want %h/%b", k, obs_paddr, obs_pwrite, a, we); else n_pass++;
      if (we) begin
        n_total++; if (obs_pwdata !== m_pwdata(sz, d)) $display("FAIL rnd_pwdata[%0d]: got %h want %h", k, obs_pwdata, m_pwdata(sz, d)); else n_pass++;
      end
      n_total++; if (obs_cycle !== m_cycle(a, w)) $display("FAIL rnd_cycle[%0d]: got %0d want %0d", k, obs_cycle, m_cycle(a, w)); else n_pass++;
      n_total++; if (obs_rdata !== er) $display("FAIL rnd_rdata[%0d]: got %h want %h", k, obs_rdata, er); else n_pass++;
      n_total++; if (obs_stable !== 1'b1 || obs_penable_setup !== 1'b0 || obs_early !== 1'b0 || obs_after_ok !== 1'b1)
        $display("FAIL rnd_protocol[%0d]: got stable=%b pen_setup=%b early=%b after=%b want 1/0/0/1",
                 k, obs_stable, obs_penable_setup, obs_early, obs_after_ok); else n_pass++;
    end
  endtask

`ifdef APB_TIMEOUT_EN
  task automatic test_timeout;
    logic [31:0] exp_d;
    do_txn(1'b0, 32'h1000_1000, 32'h0, 3'b010, 1000);
    n_total++; if (obs_cycle !== 2 + TO) $display("FAIL to_cycle: got %0d want %0d", obs_cycle, 2 + TO); else n_pass++;
    n_total++; if (obs_rdata !== 32'hDEAD_BEEF) $display("FAIL to_rdata: got %h want deadbeef", obs_rdata); else n_pass++;
    n_total++; if (obs_after_ok !== 1'b1) $display("FAIL to_idle_after: got %b want 1", obs_after_ok); else n_pass++;
    do_txn(1'b0, 32'h1000_2000, 32'h0, 3'b010, TO);
    exp_d = PRDATA[2];
    n_total++; if (obs_cycle !== 2 + TO) $display("FAIL to_race_cycle: got %0d want %0d", obs_cycle, 2 + TO); else n_pass++;
    n_total++; if (obs_rdata !== exp_d) $display("FAIL to_race_rdata: got %h want %h", obs_rdata, exp_d); else n_pass++;
  endtask
`endif

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_word_write();
    test_byte_write();
    test_wait_read();
    test_decode_miss();
    test_reset_mid();
    test_back_to_back();
    test_random();
`ifdef APB_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
